// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_PEND,
    S_DROP
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/if_pc_fetch.sv
// Instruction-fetch front end: owns the PC, runs a single-outstanding request/ack
// memory port and presents fetched words to decode through a valid/stall register.
// A redirect never lets a word fetched before it reach decode afterwards.
module if_pc_fetch
  import if_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_use_branch,
  input  logic [ADDR_WIDTH-1:0] i_branch_out,
  input  logic                  i_flush,
  input  logic                  i_stall,
  output logic                  o_imem_req,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_if_valid,
  output logic [ADDR_WIDTH-1:0] o_if_pc,
  output logic [DATA_WIDTH-1:0] o_if_instr
);

  // Low during reset and for the first cycle after it, so the first request
  // rises one cycle after release and acks arriving before then are ignored.
  logic                  r_run;
  fetch_state_t          r_state, w_state_d;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_d;
  // Address of the request being drained in S_DROP; r_pc already holds the target.
  logic [ADDR_WIDTH-1:0] r_stale, w_stale_d;
  logic [ADDR_WIDTH-1:0] r_pend_pc, w_pend_pc_d;
  logic [DATA_WIDTH-1:0] r_pend_instr, w_pend_instr_d;
  logic                  r_if_valid, w_if_valid_d;
  logic [ADDR_WIDTH-1:0] r_if_pc, w_if_pc_d;
  logic [DATA_WIDTH-1:0] r_if_instr, w_if_instr_d;

  logic                  w_ack;
  logic                  w_slot_free;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_target;

  assign o_imem_req  = r_run && (r_state != S_PEND);
  assign o_imem_addr = (r_state == S_DROP) ? r_stale : r_pc;
  assign o_if_valid  = r_if_valid;
  assign o_if_pc     = r_if_pc;
  assign o_if_instr  = r_if_instr;

  assign w_ack    = i_imem_ack && o_imem_req;
  // A flushed output word is dead, so a same-cycle ack may overwrite it.
  assign w_slot_free = !r_if_valid || !i_stall || i_flush;
  assign w_pc_inc = r_pc + ADDR_WIDTH'(INSTR_BYTES);
  assign w_target = {i_branch_out[ADDR_WIDTH-1:2], 2'b00};

  // Next-state: redirect first, then flush, then the normal fetch/present flow.
  always_comb begin
    w_state_d      = r_state;
    w_pc_d         = r_pc;
    w_stale_d      = r_stale;
    w_pend_pc_d    = r_pend_pc;
    w_pend_instr_d = r_pend_instr;
    w_if_valid_d   = r_if_valid;
    w_if_pc_d      = r_if_pc;
    w_if_instr_d   = r_if_instr;

    // Decode consumed (or nothing was held): drop valid unless reloaded below.
    if (!i_stall) w_if_valid_d = 1'b0;

    if (i_use_branch) begin
      w_pc_d       = w_target;
      w_if_valid_d = 1'b0;
      case (r_state)
        S_REQ: begin
          // An unacked request must still complete; drain it at the old address.
          if (o_imem_req && !w_ack) begin
            w_state_d = S_DROP;
            w_stale_d = r_pc;
          end
        end
        S_PEND:  w_state_d = S_REQ;
        S_DROP:  if (w_ack) w_state_d = S_REQ;
        default: w_state_d = S_REQ;
      endcase
    end else begin
      if (i_flush) w_if_valid_d = 1'b0;
      case (r_state)
        S_REQ: begin
          if (w_ack) begin
            w_pc_d = w_pc_inc;
            if (w_slot_free) begin
              w_if_valid_d = 1'b1;
              w_if_pc_d    = r_pc;
              w_if_instr_d = i_imem_rdata;
            end else begin
              w_pend_pc_d    = r_pc;
              w_pend_instr_d = i_imem_rdata;
              w_state_d      = S_PEND;
            end
          end
        end
        S_PEND: begin
          if (i_flush) begin
            w_state_d = S_REQ;
          end else if (!i_stall) begin
            w_if_valid_d = 1'b1;
            w_if_pc_d    = r_pend_pc;
            w_if_instr_d = r_pend_instr;
            w_state_d    = S_REQ;
          end
        end
        S_DROP:  if (w_ack) w_state_d = S_REQ;
        default: w_state_d = S_REQ;
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run        <= 1'b0;
      r_state      <= S_REQ;
      r_pc         <= PC_ADDR;
      r_stale      <= PC_ADDR;
      r_pend_pc    <= PC_ADDR;
      r_pend_instr <= DATA_WIDTH'(NOP_INSTR);
      r_if_valid   <= 1'b0;
      r_if_pc      <= PC_ADDR;
      r_if_instr   <= DATA_WIDTH'(NOP_INSTR);
    end else begin
      r_run        <= 1'b1;
      r_state      <= w_state_d;
      r_pc         <= w_pc_d;
      r_stale      <= w_stale_d;
      r_pend_pc    <= w_pend_pc_d;
      r_pend_instr <= w_pend_instr_d;
      r_if_valid   <= w_if_valid_d;
      r_if_pc      <= w_if_pc_d;
      r_if_instr   <= w_if_instr_d;
    end
  end

endmodule
